// File: rtl/cnn_cls_pkg.sv
// Shared types and default sizing for the CNN classification stage.
// Optional build macro used by this stage: CLASSIFIER_MARGIN_EN.
package cnn_cls_pkg;

  localparam int DEF_INPUT_BITS = 12;
  localparam int DEF_NUM_CLASS  = 10;
  localparam int DEF_IDX_BITS   = 4;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCAN    = 2'd1,
    HOLD    = 2'd2
  } cls_state_e;

  typedef logic signed [DEF_INPUT_BITS-1:0] score_t;

endpackage

// File: rtl/cls_score_buf.sv
// Frame buffer for class scores: one synchronous write port, one
// combinational read port. Contents are not reset.
module cls_score_buf #(
  parameter int W  = 12,
  parameter int N  = 10,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we && (waddr < AW'(N))) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (raddr < AW'(N)) ? mem[raddr] : '0;

endmodule

// File: rtl/classifier_argmax_sched.sv
// Buffers one frame of signed class scores, runs a serial argmax with a single
// comparator, and hands the winner downstream. CLASSIFIER_MARGIN_EN adds a margin output.
module classifier_argmax_sched
  import cnn_cls_pkg::*;
#(
  parameter int INPUT_BITS = DEF_INPUT_BITS,
  parameter int NUM_CLASS  = DEF_NUM_CLASS,
  parameter int IDX_BITS   = DEF_IDX_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INPUT_BITS-1:0]        in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IDX_BITS-1:0]          class_idx,
  output logic signed [INPUT_BITS-1:0] max_score,
  output logic                         frame_err,
`ifdef CLASSIFIER_MARGIN_EN
  output logic [INPUT_BITS:0]          margin,
`endif
  output cls_state_e                   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; a producer holds its data stable while valid is high and ready low.

  cls_state_e state, state_nxt;
  logic [IDX_BITS-1:0]          cnt, cnt_nxt;
  logic signed [INPUT_BITS-1:0] run_max, run_max_nxt;
  logic [IDX_BITS-1:0]          run_idx, run_idx_nxt;
  logic [IDX_BITS-1:0]          class_idx_nxt;
  logic signed [INPUT_BITS-1:0] max_score_nxt;
  logic                         out_valid_nxt, frame_err_nxt;
  logic signed [INPUT_BITS-1:0] rd_data;
  logic                         beat_acc, last_slot;
`ifdef CLASSIFIER_MARGIN_EN
  logic signed [INPUT_BITS-1:0] run_2nd, run_2nd_nxt;
  logic [INPUT_BITS:0]          margin_nxt;
`endif

  assign in_ready  = (state == COLLECT);
  assign beat_acc  = in_valid & in_ready;
  assign last_slot = (cnt == IDX_BITS'(NUM_CLASS - 1));
  assign dbg_state = state;

  // cnt is the write address while collecting and the scan index while scanning.
  cls_score_buf #(.W(INPUT_BITS), .N(NUM_CLASS), .AW(IDX_BITS)) u_buf (
    .clk   (clk),
    .we    (beat_acc),
    .waddr (cnt),
    .wdata (in_data),
    .raddr (cnt),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      cnt       <= '0;
      run_max   <= '0;
      run_idx   <= '0;
      class_idx <= '0;
      max_score <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      run_max   <= run_max_nxt;
      run_idx   <= run_idx_nxt;
      class_idx <= class_idx_nxt;
      max_score <= max_score_nxt;
      out_valid <= out_valid_nxt;
      frame_err <= frame_err_nxt;
    end
  end

`ifdef CLASSIFIER_MARGIN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      run_2nd <= '0;
      margin  <= '0;
    end else begin
      run_2nd <= run_2nd_nxt;
      margin  <= margin_nxt;
    end
  end
`endif

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    run_max_nxt   = run_max;
    run_idx_nxt   = run_idx;
    class_idx_nxt = class_idx;
    max_score_nxt = max_score;
    out_valid_nxt = out_valid;
    frame_err_nxt = 1'b0;
`ifdef CLASSIFIER_MARGIN_EN
    run_2nd_nxt   = run_2nd;
    margin_nxt    = margin;
`endif
    case (state)
      COLLECT: begin
        if (beat_acc) begin
          if (last_slot) begin
            cnt_nxt       = '0;
            state_nxt     = SCAN;
            frame_err_nxt = ~in_last;
          end else if (in_last) begin
            cnt_nxt       = '0;
            frame_err_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + IDX_BITS'(1);
          end
        end
      end
      SCAN: begin
        // Index 0 seeds the running max; strict > keeps the lowest index on ties.
        if (cnt == '0) begin
          run_max_nxt = rd_data;
          run_idx_nxt = '0;
`ifdef CLASSIFIER_MARGIN_EN
          run_2nd_nxt = {1'b1, {(INPUT_BITS-1){1'b0}}};
`endif
        end else if (rd_data > run_max) begin
          run_max_nxt = rd_data;
          run_idx_nxt = cnt;
`ifdef CLASSIFIER_MARGIN_EN
          run_2nd_nxt = run_max;
        end else if (rd_data >= run_2nd) begin
          run_2nd_nxt = rd_data;
`endif
        end
        if (last_slot) begin
          class_idx_nxt = run_idx_nxt;
          max_score_nxt = run_max_nxt;
          out_valid_nxt = 1'b1;
          cnt_nxt       = '0;
          state_nxt     = HOLD;
`ifdef CLASSIFIER_MARGIN_EN
          margin_nxt = {run_max_nxt[INPUT_BITS-1], run_max_nxt}
                     - {run_2nd_nxt[INPUT_BITS-1], run_2nd_nxt};
`endif
        end else begin
          cnt_nxt = cnt + IDX_BITS'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

endmodule

// File: tb/tb_classifier_argmax_sched.sv
// Randomized bench for classifier_argmax_sched against a frame-level argmax model.
// Honours CLASSIFIER_MARGIN_EN to also check the margin output.
module tb_classifier_argmax_sched;
  import cnn_cls_pkg::*;

  localparam int INPUT_BITS = 12;
  localparam int NUM_CLASS  = 10;
  localparam int IDX_BITS   = 4;
  localparam int PW = IDX_BITS + 2 * INPUT_BITS + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                         in_valid, in_ready, in_last;
  logic [INPUT_BITS-1:0]        in_data;
  logic                         out_valid, out_ready, frame_err;
  logic [IDX_BITS-1:0]          class_idx;
  logic signed [INPUT_BITS-1:0] max_score;
  cls_state_e                   dbg_state;
`ifdef CLASSIFIER_MARGIN_EN
  logic [INPUT_BITS:0]          margin;
`endif

  classifier_argmax_sched #(
    .INPUT_BITS(INPUT_BITS), .NUM_CLASS(NUM_CLASS), .IDX_BITS(IDX_BITS)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .class_idx(class_idx), .max_score(max_score), .frame_err(frame_err),
`ifdef CLASSIFIER_MARGIN_EN
    .margin(margin),
`endif
    .dbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [PW-1:0] exp_q[$];
  bit  busy = 0, pending_clear = 0, chk_en = 0;
  int  done_cyc = 0, err_cyc = -1;
  int  or_mode = 2;   // 0 random, 1 stall, 2 always ready

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level reference: first strict maximum, margin against the best other entry.
  function automatic logic [PW-1:0] model(input int sc[16]);
    int bi, bv, sv;
    bi = 0; bv = sc[0];
    for (int i = 1; i < NUM_CLASS; i++) if (sc[i] > bv) begin bv = sc[i]; bi = i; end
    sv = -(1 << 30);
    for (int i = 0; i < NUM_CLASS; i++) if (i != bi && sc[i] > sv) sv = sc[i];
    return {IDX_BITS'(bi), INPUT_BITS'(bv), (INPUT_BITS+1)'(bv - sv)};
  endfunction

  // ---------------- downstream ready driver ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        0: out_ready = ($urandom_range(0, 2) != 0);
        1: out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [PW-1:0] e;
    logic signed [INPUT_BITS-1:0] e_sc;
    bit exp_ov;
    if (chk_en && !rst) begin
      if (pending_clear) begin busy = 0; pending_clear = 0; end
      check("in_ready", int'(in_ready), int'(!busy));
      exp_ov = busy && (cyc >= done_cyc + NUM_CLASS);
      check("out_valid", int'(out_valid), int'(exp_ov));
      check("frame_err", int'(frame_err), int'(cyc == err_cyc));
      if (out_valid && exp_ov) begin
        if (exp_q.size() == 0) check("exp_q_nonempty", 0, 1);
        else begin
          e = exp_q[0];
          e_sc = e[2*INPUT_BITS -: INPUT_BITS];
          check("class_idx", int'(class_idx), int'(e[PW-1 -: IDX_BITS]));
          check("max_score", int'(max_score), int'(e_sc));
`ifdef CLASSIFIER_MARGIN_EN
          check("margin", int'(margin), int'(e[INPUT_BITS:0]));
`endif
          if (out_ready) begin
            void'(exp_q.pop_front());
            pending_clear = 1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    chk_en = 0;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete(); busy = 0; pending_clear = 0; err_cyc = -1;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_class_idx", int'(class_idx), 0);
    check("rst_max_score", int'(max_score), 0);
    check("rst_frame_err", int'(frame_err), 0);
`ifdef CLASSIFIER_MARGIN_EN
    check("rst_margin", int'(margin), 0);
`endif
    chk_en = 1;
    @(posedge clk); #1;
  endtask

  // Sends nb beats; last_flag puts in_last on the final beat. track=0 leaves the model untouched.
  task automatic send_frame(input int sc[16], input int nb, input bit last_flag, input bit track);
    bit acc;
    int tmo;
    for (int b = 0; b < nb; b++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) begin
        in_data = INPUT_BITS'($urandom); @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = INPUT_BITS'(sc[b]);
      in_last  = last_flag && (b == nb - 1);
      tmo = 0;
      do begin
        @(negedge clk); acc = in_ready;
        @(posedge clk); #1;
        tmo++;
      end while (!acc && tmo < 200);
      in_valid = 1'b0; in_last = 1'b0;
      if (!acc) begin check("in_ready_timeout", 0, 1); return; end
    end
    if (track) begin
      if (nb == NUM_CLASS) begin
        exp_q.push_back(model(sc));
        busy = 1; done_cyc = cyc;
        if (!last_flag) err_cyc = cyc;
      end else if (last_flag) begin
        err_cyc = cyc;
      end
    end
  endtask

  task automatic wait_result(input int idx, input int score, input int marg);
    int tmo = 0;
    do begin @(negedge clk); tmo++; end while (!out_valid && tmo < 100);
    check("res_seen", int'(out_valid), 1);
    check("res_latency", cyc - done_cyc, 10);
    check("res_idx", int'(class_idx), idx);
    check("res_score", int'(max_score), score);
`ifdef CLASSIFIER_MARGIN_EN
    check("res_margin", int'(margin), marg);
`else
    if (marg < 0) check("res_margin_arg", marg, 0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sc[16], sb[16];
    int r, nb, tmo;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    do_reset(3);

    sc = '{3, -5, 7, 0, 12, -1, 4, 9, 2, 11, 0, 0, 0, 0, 0, 0};
    send_frame(sc, NUM_CLASS, 1, 1);
    wait_result(4, 12, 1);

    sb = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 0, 0, 0, 0, 0, 0};
    @(posedge clk); #1;
    send_frame(sb, NUM_CLASS, 1, 1);
    wait_result(0, 5, 0);

    sb = '{-2048, -7, -3, -100, -3, -2048, -9, -50, -4, -8, 0, 0, 0, 0, 0, 0};
    @(posedge clk); #1;
    send_frame(sb, NUM_CLASS, 1, 1);
    wait_result(2, -3, 0);

    // Early in_last on beat 5, then a good frame with the max at the last index.
    @(posedge clk); #1;
    send_frame(sc, 6, 1, 1);
    @(negedge clk);
    check("early_last_err", int'(frame_err), 1);
    repeat (NUM_CLASS + 3) @(negedge clk);
    @(posedge clk); #1;
    sb = '{1, 2, 3, 4, 5, 6, 7, 8, 100, 2047, 0, 0, 0, 0, 0, 0};
    send_frame(sb, NUM_CLASS, 1, 1);
    wait_result(9, 2047, 1947);

    // Backpressure: hold the result 20 cycles while the next frame waits upstream.
    @(posedge clk); #1;
    or_mode = 1;
    send_frame(sc, NUM_CLASS, 1, 1);
    fork
      begin
        wait_result(4, 12, 1);
        repeat (20) begin
          @(negedge clk);
          check("hold_idx", int'(class_idx), 4);
          check("hold_valid", int'(out_valid), 1);
          check("hold_in_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        or_mode = 2;
      end
      send_frame(sb, NUM_CLASS, 1, 1);
    join
    wait_result(9, 2047, 1947);

    // Reset after beat 6 of a frame, then during SCAN.
    @(posedge clk); #1;
    send_frame(sc, 7, 0, 0);
    do_reset(2);
    send_frame(sc, NUM_CLASS, 1, 1);
    repeat (4) @(posedge clk);
    #1 do_reset(1);
    repeat (NUM_CLASS + 4) @(negedge clk);
    @(posedge clk); #1;
    send_frame(sb, NUM_CLASS, 1, 1);
    wait_result(9, 2047, 1947);

    // Randomized frames with random gaps, framing faults and downstream stalls.
    @(posedge clk); #1;
    or_mode = 0;
    for (int f = 0; f < 40; f++) begin
      bit narrow = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 16; i++)
        sc[i] = narrow ? int'($urandom_range(0, 3)) - 2 : int'($urandom_range(0, 4095)) - 2048;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        nb = $urandom_range(1, NUM_CLASS - 1);
        send_frame(sc, nb, 1, 1);
      end else begin
        send_frame(sc, NUM_CLASS, (r != 1), 1);
      end
    end
    or_mode = 2;
    tmo = 0;
    while ((busy || exp_q.size() != 0) && tmo < 200) begin @(negedge clk); tmo++; end
    check("drain", int'(exp_q.size()), 0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
